// File: rtl/rnn_pkg.sv
// Shared definitions for the denoise RNN layer scheduler: layer IDs,
// FSM state encoding, engine feature widths and stage helpers.
package rnn_pkg;

    localparam int N_LAYERS = 6;

    // Layer IDs index layer_start / layer_done and are reported in err_layer
    localparam logic [2:0] L_DENSE_IN    = 3'd0;
    localparam logic [2:0] L_VAD_GRU     = 3'd1;
    localparam logic [2:0] L_VAD_OUT     = 3'd2;
    localparam logic [2:0] L_NOISE_GRU   = 3'd3;
    localparam logic [2:0] L_DENOISE_GRU = 3'd4;
    localparam logic [2:0] L_DENOISE_OUT = 3'd5;

    // Feature widths consumed by the layer engines
    localparam int FEAT_W_IN      = 42;
    localparam int FEAT_W_VAD     = 24;
    localparam int FEAT_W_DENOISE = 90;

    typedef enum logic [3:0] {
        IDLE, CLEAR, S_DIN, S_VGRU, S_PAR, S_DGRU, S_DOUT, EMIT, ERROR
    } state_t;

    // Start pulses issued on entry to a layer stage
    function automatic logic [N_LAYERS-1:0] start_bits(input state_t s);
        start_bits = '0;
        case (s)
            S_DIN:  start_bits[L_DENSE_IN]    = 1'b1;
            S_VGRU: start_bits[L_VAD_GRU]     = 1'b1;
            S_PAR: begin
                start_bits[L_VAD_OUT]   = 1'b1;
                start_bits[L_NOISE_GRU] = 1'b1;
            end
            S_DGRU: start_bits[L_DENOISE_GRU] = 1'b1;
            S_DOUT: start_bits[L_DENOISE_OUT] = 1'b1;
            default: ;
        endcase
    endfunction

    // Dependency order of the layer stages; the last stage hands off to EMIT
    function automatic state_t next_stage(input state_t s);
        case (s)
            S_DIN:   next_stage = S_VGRU;
            S_VGRU:  next_stage = S_PAR;
            S_PAR:   next_stage = S_DGRU;
            S_DGRU:  next_stage = S_DOUT;
            S_DOUT:  next_stage = EMIT;
            default: next_stage = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rnn_watchdog.sv
// Per-layer watchdog: cleared on each layer start, counts while a layer
// stage is active, and flags expiry on the cycle whose increment would
// bring the count to TIMEOUT_CYCLES-1 (so ERROR is entered TIMEOUT_CYCLES-1
// cycles after the start pulse).
module rnn_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // Cycle counter: zero on reset or on a new start, else count while enabled
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && !load && (cnt == CW'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/rnn_layer_sched.sv
// Frame-level sequencer for the denoise RNN: accepts a feature frame, starts
// the layer engines in dependency order, collects their dones, hands the
// result to the consumer and traps into ERROR if any layer stalls.
module rnn_layer_sched
    import rnn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   feat_valid,
    output logic                   feat_ready,
    output logic                   feat_latch,
    input  logic                   clear_req,
    output logic                   gru_clear,
    output logic [N_LAYERS-1:0]    layer_start,
    input  logic [N_LAYERS-1:0]    layer_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [2:0]             err_layer,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    state_t                state;
    logic [1:0]            seen_par;   // [0]: VAD_OUT done seen, [1]: NOISE_GRU done seen
    logic [N_LAYERS-1:0]   done_live;
    logic                  got2;
    logic                  got3;
    logic                  advance;
    logic [2:0]            pend_layer;
    logic                  in_layer;
    logic                  wd_expire;

    // Frames are refused during reset so nothing is latched that the FSM discards
    assign feat_ready = (state == IDLE) && !clear_req && !rst;
    assign feat_latch = feat_valid && feat_ready;
    assign busy       = (state != IDLE);
    assign in_layer   = state inside {S_DIN, S_VGRU, S_PAR, S_DGRU, S_DOUT};

    // Decode whether the current stage's awaited done(s) are complete
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        done_live  = (layer_start == '0) ? layer_done : '0;
        got2       = seen_par[0] | done_live[L_VAD_OUT];
        got3       = seen_par[1] | done_live[L_NOISE_GRU];
        advance    = 1'b0;
        pend_layer = L_DENSE_IN;
        case (state)
            S_DIN: begin
                advance    = done_live[L_DENSE_IN];
                pend_layer = L_DENSE_IN;
            end
            S_VGRU: begin
                advance    = done_live[L_VAD_GRU];
                pend_layer = L_VAD_GRU;
            end
            S_PAR: begin
                advance    = got2 & got3;
                pend_layer = got2 ? L_NOISE_GRU : L_VAD_OUT;
            end
            S_DGRU: begin
                advance    = done_live[L_DENOISE_GRU];
                pend_layer = L_DENOISE_GRU;
            end
            S_DOUT: begin
                advance    = done_live[L_DENOISE_OUT];
                pend_layer = L_DENOISE_OUT;
            end
            default: ;
        endcase
    end

    rnn_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (feat_latch | advance),
        .en     (in_layer),
        .expire (wd_expire)
    );

    // Scheduler FSM with registered start/clear/valid/error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            seen_par    <= '0;
            layer_start <= '0;
            gru_clear   <= 1'b0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
            err_layer   <= '0;
            frame_cnt   <= '0;
        end else begin
            layer_start <= '0;
            gru_clear   <= 1'b0;
            if (wd_expire && !advance) begin
                state       <= ERROR;
                timeout_err <= 1'b1;
                err_layer   <= pend_layer;
            end else begin
                case (state)
                    IDLE: begin
                        if (clear_req) begin
                            state <= CLEAR;
                        end else if (feat_latch) begin
                            state       <= S_DIN;
                            layer_start <= start_bits(S_DIN);
                        end
                    end
                    CLEAR: begin
                        // Pulse lands in the following IDLE cycle, never while busy
                        gru_clear <= 1'b1;
                        state     <= IDLE;
                    end
                    S_DIN, S_VGRU, S_PAR, S_DGRU, S_DOUT: begin
                        seen_par <= {got3, got2};
                        if (advance) begin
                            state       <= next_stage(state);
                            layer_start <= start_bits(next_stage(state));
                            out_valid   <= (next_stage(state) == EMIT);
                            seen_par    <= '0;
                        end
                    end
                    EMIT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            frame_cnt <= frame_cnt + 1'b1;
                            state     <= IDLE;
                        end
                    end
                    ERROR: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rnn_layer_sched.sv
// Self-checking bench for rnn_layer_sched: table-driven frames with
// per-layer engine latencies, hand-written clear/reset sequences and
// randomized frames checked against a stage-timing model.
module tb_rnn_layer_sched;

    localparam int TO    = 16;
    localparam int FCW   = 2;
    localparam int NEVER = 99;

    logic           clk = 1'b0;
    logic           rst;
    logic           feat_valid;
    logic           feat_ready;
    logic           feat_latch;
    logic           clear_req;
    logic           gru_clear;
    logic [5:0]     layer_start;
    logic [5:0]     layer_done;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           timeout_err;
    logic [2:0]     err_layer;
    logic [FCW-1:0] frame_cnt;

    rnn_layer_sched #(
        .TIMEOUT_CYCLES (TO),
        .FRAME_CNT_W    (FCW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .feat_valid  (feat_valid),
        .feat_ready  (feat_ready),
        .feat_latch  (feat_latch),
        .clear_req   (clear_req),
        .gru_clear   (gru_clear),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_layer   (err_layer),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int dly[6] = '{1, 1, 1, 1, 1, 1};
    int due[6];
    int start_t[6];
    int clr_cnt  = 0;
    int clr_busy = 0;
    int exp_cnt  = 0;
    int n_vec    = 0;
    int n_bad    = 0;

    // Model outputs (times relative to the accept cycle)
    int exp_st[6];
    int exp_end;
    bit exp_err;
    int exp_lay;

    typedef struct {
        int d0, d1, d2, d3, d4, d5;
        int hold;
        int end_t;
        bit err;
        int lay;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Engines answer each start after dly cycles; monitor records starts and clears
    initial begin
        layer_done = '0;
        for (int i = 0; i < 6; i++) due[i] = -1;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 6; i++) layer_done[i] = (due[i] == cyc);
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (layer_start[i] === 1'b1) begin
                    start_t[i] = cyc;
                    if (dly[i] < NEVER) due[i] = cyc + dly[i];
                end
            end
            if (gru_clear === 1'b1) begin
                clr_cnt++;
                if (busy !== 1'b0) clr_busy++;
            end
        end
    end

    // Stage timing: each stage starts one cycle after the previous stage's
    // last done; a stage whose wait exceeds TO-2 cycles times out TO-1 cycles
    // after its start, blaming the lowest layer still pending.
    function automatic void model();
        int t, w, a, b;
        t       = 1;
        exp_err = 1'b0;
        exp_lay = 0;
        for (int i = 0; i < 6; i++) exp_st[i] = -1;
        for (int s = 0; s < 5; s++) begin
            case (s)
                0:       begin a = 0; b = 0; end
                1:       begin a = 1; b = 1; end
                2:       begin a = 2; b = 3; end
                3:       begin a = 4; b = 4; end
                default: begin a = 5; b = 5; end
            endcase
            exp_st[a] = t;
            exp_st[b] = t;
            w = (dly[a] > dly[b]) ? dly[a] : dly[b];
            if (w > TO - 2) begin
                exp_err = 1'b1;
                exp_lay = (dly[a] > TO - 2) ? a : b;
                exp_end = t + TO - 1;
                return;
            end
            t = t + w + 1;
        end
        exp_end = t;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        next_cycle();
        rst        = 1'b1;
        feat_valid = 1'b0;
        clear_req  = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 6; i++) due[i] = -1;
        @(negedge clk);
        check({tag, " feat_ready_in_reset"}, feat_ready, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check({tag, " busy"}, busy, 0);
        check({tag, " feat_ready"}, feat_ready, 1);
        check({tag, " layer_start"}, layer_start, 0);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " timeout_err"}, timeout_err, 0);
        check({tag, " err_layer"}, err_layer, 0);
        check({tag, " frame_cnt"}, frame_cnt, 0);
        check({tag, " gru_clear"}, gru_clear, 0);
        exp_cnt = 0;
    endtask

    task automatic run_frame(input int e_end, input bit e_err, input int e_lay,
                             input int hold, input bit pre_clear, input int id);
        int    t0, c0, tend, clr0, stray;
        string tag;
        tag = $sformatf("frame%0d", id);
        model();
        for (int i = 0; i < 6; i++) start_t[i] = -1;
        next_cycle();
        feat_valid = 1'b1;
        clear_req  = pre_clear;
        c0         = cyc;
        clr0       = clr_cnt;
        t0         = -1;
        for (int k = 0; k < 20 && t0 < 0; k++) begin
            @(negedge clk);
            if (pre_clear && k == 0) check({tag, " latch_during_clear"}, feat_latch, 0);
            if (feat_latch === 1'b1) t0 = cyc;
            next_cycle();
            clear_req = 1'b0;
            if (t0 >= 0) feat_valid = 1'b0;
        end
        if (t0 < 0) begin
            feat_valid = 1'b0;
            check({tag, " accept_seen"}, feat_latch, 1);
            return;
        end
        if (pre_clear) check({tag, " accept_delay"}, t0 - c0, 2);
        tend = -1;
        for (int k = 0; k < 300 && tend < 0; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1 || timeout_err === 1'b1) tend = cyc;
        end
        check({tag, " end_time"}, (tend < 0) ? -1 : tend - t0, e_end);
        check({tag, " err_flag"}, timeout_err, e_err);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s start%0d", tag, i),
                  (start_t[i] < 0) ? -1 : start_t[i] - t0, exp_st[i]);
        if (e_err) begin
            check({tag, " err_layer"}, err_layer, e_lay);
            stray = 0;
            for (int k = 0; k < 10; k++) begin
                next_cycle();
                feat_valid = 1'b1;
                @(negedge clk);
                if (layer_start !== 6'd0 || feat_latch !== 1'b0 || out_valid !== 1'b0 ||
                    busy !== 1'b1 || timeout_err !== 1'b1 || feat_ready !== 1'b0)
                    stray++;
            end
            check({tag, " stuck_in_error"}, stray, 0);
            do_reset({tag, " post_error_reset"});
        end else begin
            for (int h = 0; h < hold; h++) begin
                next_cycle();
                @(negedge clk);
                check({tag, " held_out_valid"}, out_valid, 1);
                check({tag, " held_feat_ready"}, feat_ready, 0);
            end
            next_cycle();
            out_ready = 1'b1;
            @(negedge clk);
            next_cycle();
            out_ready = 1'b0;
            exp_cnt   = (exp_cnt + 1) % (1 << FCW);
            @(negedge clk);
            check({tag, " out_valid_after"}, out_valid, 0);
            check({tag, " frame_cnt"}, frame_cnt, exp_cnt);
            check({tag, " feat_ready_after"}, feat_ready, 1);
            check({tag, " busy_after"}, busy, 0);
        end
        if (pre_clear) check({tag, " gru_clear_pulses"}, clr_cnt - clr0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int found, stray;
        rst        = 1'b1;
        feat_valid = 1'b0;
        clear_req  = 1'b0;
        out_ready  = 1'b0;

        //           d0  d1  d2     d3     d4  d5     hold end err lay
        tbl[0]  = '{ 1,  1,  1,     1,     1,  1,     0,   11, 0,  0};  // nominal
        tbl[1]  = '{ 1,  1,  7,     2,     1,  1,     0,   17, 0,  0};  // done3 before done2
        tbl[2]  = '{ 2,  3,  4,     4,     1,  2,     0,   18, 0,  0};  // done2/done3 together
        tbl[3]  = '{ 1,  1,  1,     1,     1,  1,     5,   11, 0,  0};  // consumer stalls
        tbl[4]  = '{ 3,  1,  5,     1,     2,  1,     1,   18, 0,  0};  // frame_cnt wrapped
        tbl[5]  = '{14,  1,  1,     1,     1,  1,     0,   24, 0,  0};  // latest legal done
        tbl[6]  = '{ 1,  1, 14,     3,     1,  1,     0,   24, 0,  0};  // latest legal in PAR
        tbl[7]  = '{ 1, NEVER, 1,   1,     1,  1,     0,   18, 1,  1};  // done1 withheld
        tbl[8]  = '{15,  1,  1,     1,     1,  1,     0,   16, 1,  0};  // one cycle too late
        tbl[9]  = '{ 1,  1,  1, NEVER,     1,  1,     0,   20, 1,  3};  // PAR, only 3 pending
        tbl[10] = '{ 1,  1, NEVER, NEVER,  1,  1,     0,   20, 1,  2};  // PAR, both pending
        tbl[11] = '{ 1,  1,  1,     1,     1, NEVER,  0,   24, 1,  5};  // last layer stalls

        do_reset("reset");

        for (int v = 0; v < 12; v++) begin
            dly[0] = tbl[v].d0; dly[1] = tbl[v].d1; dly[2] = tbl[v].d2;
            dly[3] = tbl[v].d3; dly[4] = tbl[v].d4; dly[5] = tbl[v].d5;
            run_frame(tbl[v].end_t, tbl[v].err, tbl[v].lay, tbl[v].hold, 1'b0, v);
        end

        // clear_req and feat_valid together: clear first, accept two cycles later
        for (int i = 0; i < 6; i++) dly[i] = 1;
        run_frame(11, 1'b0, 0, 0, 1'b1, 100);

        // Reset in S_DGRU with done4 still in flight
        dly[4] = 8;
        next_cycle();
        feat_valid = 1'b1;
        @(negedge clk);
        check("rst_mid accept", feat_latch, 1);
        next_cycle();
        feat_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (layer_start[4] === 1'b1) begin
                found = 1;
                break;
            end
            next_cycle();
        end
        check("rst_mid start4_seen", found, 1);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid feat_ready_in_reset", feat_ready, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid busy", busy, 0);
        check("rst_mid out_valid", out_valid, 0);
        check("rst_mid layer_start", layer_start, 0);
        check("rst_mid feat_ready", feat_ready, 1);
        check("rst_mid frame_cnt", frame_cnt, 0);
        check("rst_mid timeout_err", timeout_err, 0);
        exp_cnt = 0;
        stray   = 0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            @(negedge clk);
            if (busy !== 1'b0 || layer_start !== 6'd0 || out_valid !== 1'b0) stray++;
        end
        check("rst_mid late_done_ignored", stray, 0);
        dly[4] = 1;
        run_frame(11, 1'b0, 0, 0, 1'b0, 101);

        // Randomized frames against the stage-timing model
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 6; i++) dly[i] = $urandom_range(1, 14);
            if ($urandom_range(0, 7) == 0) dly[$urandom_range(0, 5)] = NEVER;
            model();
            run_frame(exp_end, exp_err, exp_lay, $urandom_range(0, 3), 1'b0, 200 + r);
        end

        check("gru_clear_while_busy", clr_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
